serial_addsub_seq: RTL and testbench



---
 rtl/arith_pkg.sv | 13 +
 rtl/full_adder_using_demux.sv | 21 ++
 rtl/serial_addsub_seq.sv | 114 +++++++++++
 tb/tb_serial_addsub_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types for the bit-serial arithmetic sequencer.
// No logic; state encoding and op codes only.
// Imported by the sequencer top.
package arith_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder_using_demux.sv
// One-bit full adder built from a 1-of-8 demux on {a,b,cin}.
// Purely combinational, zero latency.
// No flow control.
module full_adder_using_demux (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic [7:0] line;

    always_comb begin
        line = '0;
        line[{a, b, cin}] = 1'b1;
    end

    // Odd-parity minterms give the sum; minterms with two or more ones give the carry.
    assign sum  = line[1] | line[2] | line[4] | line[7];
    assign cout = line[3] | line[5] | line[6] | line[7];
endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial N-bit add/subtract using one full-adder cell, LSB first.
// Latency: start edge, then N bit edges; done pulses for one cycle after that.
// start is ignored while busy; a new request is accepted in IDLE or in the DONE cycle.
module serial_addsub_seq
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, state_nxt;
    logic [N-1:0]  a_sr, b_sr, s_sr, s_nxt;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          op_q;
    logic          cell_s, cell_c;
    logic          load;
    logic          last;

    full_adder_using_demux u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (cell_s),
        .cout (cell_c)
    );

    generate
        if (N == 1) begin : g_s1
            assign s_nxt = cell_s;
        end else begin : g_sn
            assign s_nxt = {cell_s, s_sr[N-1:1]};
        end
    endgenerate

    assign last = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            op_q  <= OP_ADD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            if (load) begin
                // Subtract runs as a + ~b + ~cin; the final carry is inverted into a borrow.
                a_sr  <= a;
                b_sr  <= (op == OP_SUB) ? ~b : b;
                carry <= cin ^ op;
                op_q  <= op;
                s_sr  <= '0;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                s_sr  <= s_nxt;
                carry <= cell_c;
                if (!last) cnt <= cnt + CW'(1);
                if (last) begin
                    sum  <= s_nxt;
                    cout <= cell_c ^ op_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for the bit-serial add/subtract sequencer (N=8 and N=1 builds).
module tb_serial_addsub_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, op, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1, op1, a1, b1, cin1;
    logic       busy1, done1, sum1, cout1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_addsub_seq #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_addsub_seq #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic issue(input logic o, input logic [7:0] av, input logic [7:0] bv, input logic c);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; cin = c;
        @(negedge clk);
        start = 1'b0; a = 8'hEE; b = 8'hDD; op = ~o; cin = ~c;
    endtask

    // Called on the first negedge after the accepting edge; counts busy cycles up to done.
    task automatic wait_done(input string name, output int nbusy);
        int guard = 0;
        nbusy = 0;
        while (!done && guard < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done=%b required 1", name, done);
        end
    endtask

    task automatic run_op(input string name, input logic o, input logic [7:0] av,
                          input logic [7:0] bv, input logic c,
                          input logic [7:0] es, input logic ec);
        int nb;
        issue(o, av, bv, c);
        wait_done(name, nb);
        checks++;
        if (sum !== es) begin
            errors++;
            $display("FAIL %s sum: got %h required %h", name, sum, es);
        end
        checks++;
        if (cout !== ec) begin
            errors++;
            $display("FAIL %s cout: got %b required %b", name, cout, ec);
        end
        checks++;
        if (nb !== 8) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required 8", name, nb);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; op = 0; a = 0; b = 0; cin = 0;
        start1 = 0; op1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b required all 0",
                     busy, done, sum, cout);
        end
    endtask

    task automatic test_add;
        run_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_00_cin", 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_sub;
        run_op("sub_10_01", 1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        run_op("sub_00_01", 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    endtask

    task automatic test_back_to_back;
        int nb;
        issue(1'b0, 8'h01, 8'h02, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; op = 1'b0; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first", nb);
        checks++;
        if (sum !== 8'h03) begin
            errors++;
            $display("FAIL b2b_ignored_start sum: got %h required 03", sum);
        end
        start = 1'b1; op = 1'b0; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b required busy=1 done=0", busy, done);
        end
        checks++;
        if (sum !== 8'h03) begin
            errors++;
            $display("FAIL b2b_sum_hold: got %h required 03", sum);
        end
        wait_done("b2b_second", nb);
        checks++;
        if (sum !== 8'h10 || nb !== 8) begin
            errors++;
            $display("FAIL b2b_second: got sum=%h busy_cycles=%0d required sum=10 busy_cycles=8",
                     sum, nb);
        end
    endtask

    task automatic test_reset_mid_op;
        issue(1'b0, 8'h33, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'b0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b sum=%h cout=%b required all 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b required 0 0", busy, done);
        end
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    endtask

    task automatic test_n1;
        @(negedge clk);
        start1 = 1'b1; op1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_shift: got busy=%b done=%b required 1 0", busy1, done1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 1'b1 || cout1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_result: got done=%b busy=%b sum=%b cout=%b required 1 0 1 1",
                     done1, busy1, sum1, cout1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_done_pulse: got %b required 0", done1);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_back_to_back;
        test_reset_mid_op;
        test_n1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
